console_line_capture: RTL and testbench

- Receive side of the simulated console.
- The file-driven command injector pushes keystrokes into the SoC. This block captures the byte stream the SoC writes to the console and assembles it into lines.
- Detects the root shell prompt so the bench can gate command injection on "prompt seen" rather than on a fixed mtime threshold.
- Completed lines are held in a buffer readable by the bench until acknowledged.

---
 rtl/console_line_capture.sv | 133 +++++++++++++
 tb/tb_console_line_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/console_line_capture.sv
// Assembles console output bytes into lines and flags the shell prompt; a line ends on
// the edge that samples its last byte, and while a line is held (o_busy) strobes are dropped.
module console_line_capture #(
    parameter int                      LINE_BYTES = 16,
    parameter int                      PROMPT_LEN = 2,
    parameter logic [8*PROMPT_LEN-1:0] PROMPT     = 16'h2320,
    parameter int                      LW         = $clog2(LINE_BYTES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_we,
    input  logic [7:0]                    i_data,
    output logic                          o_busy,
    output logic                          o_line_valid,
    output logic [LW-1:0]                 o_line_len,
    output logic                          o_line_trunc,
    output logic                          o_line_prompt,
    input  logic [$clog2(LINE_BYTES)-1:0] i_rd_addr,
    output logic [7:0]                    o_rd_data,
    input  logic                          i_line_ack,
    output logic                          o_prompt_seen,
    output logic                          o_prompt_pulse,
    output logic                          o_drop,
    output logic [31:0]                   o_byte_cnt
);

    localparam int AW = $clog2(LINE_BYTES);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              line_mem [LINE_BYTES];
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           len_inc;
    logic [8*PROMPT_LEN-1:0] cand;
    logic                    accept, store, hit_prompt, hit_full, release_line;

    assign len_inc = len_q + LW'(1);

    // Prompt candidate: already-stored leading bytes plus the byte arriving now
    always_comb begin
        cand = '0;
        for (int i = 0; i < PROMPT_LEN; i++) begin
            if (i == PROMPT_LEN - 1)
                cand[8*(PROMPT_LEN-1-i) +: 8] = i_data;
            else
                cand[8*(PROMPT_LEN-1-i) +: 8] = line_mem[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= COLLECT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        store        = 1'b0;
        hit_prompt   = 1'b0;
        hit_full     = 1'b0;
        release_line = 1'b0;
        case (state_q)
            COLLECT: begin
                if (i_we && i_data != 8'h0D) begin
                    accept = 1'b1;
                    if (i_data == 8'h0A) begin
                        state_d = HOLD;
                    end else begin
                        store = 1'b1;
                        if (len_inc == LW'(PROMPT_LEN) && cand == PROMPT) begin
                            hit_prompt = 1'b1;
                            state_d    = HOLD;
                        end else if (len_inc == LW'(LINE_BYTES)) begin
                            hit_full = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (i_line_ack) begin
                    release_line = 1'b1;
                    state_d      = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_BYTES; i++)
                line_mem[i] <= 8'h00;
            len_q          <= '0;
            o_line_trunc   <= 1'b0;
            o_line_prompt  <= 1'b0;
            o_prompt_seen  <= 1'b0;
            o_prompt_pulse <= 1'b0;
            o_drop         <= 1'b0;
            o_byte_cnt     <= 32'd0;
        end else begin
            if (store)
                line_mem[len_q[AW-1:0]] <= i_data;
            if (release_line)
                len_q <= '0;
            else if (store)
                len_q <= len_inc;
            if (release_line)
                o_line_trunc <= 1'b0;
            else if (hit_full)
                o_line_trunc <= 1'b1;
            if (release_line)
                o_line_prompt <= 1'b0;
            else if (hit_prompt)
                o_line_prompt <= 1'b1;
            o_prompt_pulse <= hit_prompt;
            if (hit_prompt)
                o_prompt_seen <= 1'b1;
            if (state_q == HOLD && i_we)
                o_drop <= 1'b1;
            if (accept)
                o_byte_cnt <= o_byte_cnt + 32'd1;
        end
    end

    assign o_busy       = (state_q == HOLD);
    assign o_line_valid = (state_q == HOLD);
    assign o_line_len   = len_q;
    assign o_rd_data    = (LW'(i_rd_addr) < len_q) ? line_mem[i_rd_addr] : 8'h00;

endmodule

// File: tb/tb_console_line_capture.sv
// Bench for console_line_capture: table of complete lines checked through a scoreboard,
// plus hand sequences for prompt pulse, truncation/drop and asynchronous reset.
module tb_console_line_capture;

    localparam int LB = 16;
    localparam int LW = $clog2(LB + 1);
    localparam int AW = $clog2(LB);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_we = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          o_busy, o_line_valid, o_line_trunc, o_line_prompt;
    logic [LW-1:0] o_line_len;
    logic [AW-1:0] i_rd_addr = '0;
    logic [7:0]    o_rd_data;
    logic          i_line_ack = 1'b0;
    logic          o_prompt_seen, o_prompt_pulse, o_drop;
    logic [31:0]   o_byte_cnt;

    console_line_capture #(.LINE_BYTES(LB), .PROMPT_LEN(2), .PROMPT(16'h2320)) dut (
        .clk(clk), .rst(rst), .i_we(i_we), .i_data(i_data),
        .o_busy(o_busy), .o_line_valid(o_line_valid), .o_line_len(o_line_len),
        .o_line_trunc(o_line_trunc), .o_line_prompt(o_line_prompt),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .i_line_ack(i_line_ack),
        .o_prompt_seen(o_prompt_seen), .o_prompt_pulse(o_prompt_pulse),
        .o_drop(o_drop), .o_byte_cnt(o_byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] seq;
        int          n;
        int          len;
        logic        trunc;
        logic        prompt;
        logic [63:0] text;
    } vec_t;

    typedef struct {
        int          len;
        logic        trunc;
        logic        prompt;
        logic [63:0] text;
    } line_t;

    vec_t  tbl [5];
    line_t sb [$];
    int    checks = 0;
    int    failures = 0;
    int    exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data = b;
        i_we   = 1'b1;
        @(posedge clk);
        #1;
        i_we   = 1'b0;
    endtask

    task automatic ack_line();
        i_line_ack = 1'b1;
        @(posedge clk);
        #1;
        i_line_ack = 1'b0;
        chk("ack_valid", o_line_valid, 0);
        chk("ack_len", o_line_len, 0);
        chk("ack_trunc", o_line_trunc, 0);
        chk("ack_prompt", o_line_prompt, 0);
    endtask

    task automatic compare_line(input line_t e);
        logic [7:0] exp_b;
        chk("line_len", o_line_len, e.len);
        chk("line_trunc", o_line_trunc, e.trunc);
        chk("line_prompt", o_line_prompt, e.prompt);
        for (int i = 0; i < LB; i++) begin
            i_rd_addr = AW'(i);
            #1;
            exp_b = 8'h00;
            if (i < e.len)
                exp_b = e.text[63-8*i -: 8];
            chk("rd_data", o_rd_data, exp_b);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        line_t      got;

        tbl[0] = '{64'h6F6B0A0000000000, 3, 2, 1'b0, 1'b0, 64'h6F6B000000000000};
        tbl[1] = '{64'h610D0A0000000000, 3, 1, 1'b0, 1'b0, 64'h6100000000000000};
        tbl[2] = '{64'h0A00000000000000, 1, 0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{64'h6162230A00000000, 4, 3, 1'b0, 1'b0, 64'h6162230000000000};
        tbl[4] = '{64'h7823200A00000000, 4, 3, 1'b0, 1'b0, 64'h7823200000000000};

        #12;
        chk("rst_valid", o_line_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_len", o_line_len, 0);
        chk("rst_cnt", o_byte_cnt, 0);
        chk("rst_seen", o_prompt_seen, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_rd", o_rd_data, 0);
        #1 rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            sb.push_back('{tbl[v].len, tbl[v].trunc, tbl[v].prompt, tbl[v].text});
            for (int k = 0; k < tbl[v].n; k++) begin
                b = tbl[v].seq[63-8*k -: 8];
                send_byte(b);
                if (b != 8'h0D)
                    exp_cnt++;
                if (o_line_valid) begin
                    if (sb.size() == 0) begin
                        chk("sb_extra_line", 1, 0);
                    end else begin
                        got = sb.pop_front();
                        compare_line(got);
                    end
                end
            end
            chk("sb_line_done", sb.size(), 0);
            chk("tbl_byte_cnt", o_byte_cnt, exp_cnt);
            ack_line();
        end
        chk("no_prompt_seen", o_prompt_seen, 0);

        // Prompt: pulse lasts one cycle, seen is sticky across ack and later lines
        send_byte(8'h23);
        chk("p1_valid", o_line_valid, 0);
        chk("p1_pulse", o_prompt_pulse, 0);
        send_byte(8'h20);
        chk("p2_valid", o_line_valid, 1);
        chk("p2_prompt", o_line_prompt, 1);
        chk("p2_trunc", o_line_trunc, 0);
        chk("p2_len", o_line_len, 2);
        chk("p2_pulse", o_prompt_pulse, 1);
        chk("p2_seen", o_prompt_seen, 1);
        @(posedge clk);
        #1;
        chk("p3_pulse", o_prompt_pulse, 0);
        chk("p3_valid", o_line_valid, 1);
        ack_line();
        chk("p4_seen", o_prompt_seen, 1);
        send_byte(8'h7A);
        send_byte(8'h0A);
        chk("p5_len", o_line_len, 1);
        chk("p5_seen", o_prompt_seen, 1);
        chk("p5_pulse", o_prompt_pulse, 0);
        ack_line();

        // Truncation after 16 bytes, then dropped strobes
        rst = 1'b1;
        #1;
        chk("rst2_seen", o_prompt_seen, 0);
        rst = 1'b0;
        for (int k = 0; k < LB; k++) begin
            b = (k < 10) ? 8'(8'h30 + k) : 8'(8'h61 + k - 10);
            send_byte(b);
            if (k == LB - 2)
                chk("tr_not_yet", o_line_valid, 0);
        end
        chk("tr_valid", o_line_valid, 1);
        chk("tr_trunc", o_line_trunc, 1);
        chk("tr_prompt", o_line_prompt, 0);
        chk("tr_len", o_line_len, 16);
        chk("tr_cnt", o_byte_cnt, 16);
        i_rd_addr = AW'(15);
        #1;
        chk("tr_rd15", o_rd_data, 8'h66);
        send_byte(8'h58);
        chk("tr_drop", o_drop, 1);
        chk("tr_cnt_hold", o_byte_cnt, 16);
        i_line_ack = 1'b1;
        send_byte(8'h0A);
        i_line_ack = 1'b0;
        chk("ackwe_valid", o_line_valid, 0);
        chk("ackwe_cnt", o_byte_cnt, 16);
        chk("ackwe_rd", o_rd_data, 0);

        // Asynchronous reset mid-line
        send_byte(8'h61);
        send_byte(8'h62);
        chk("mid_len", o_line_len, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_len", o_line_len, 0);
        chk("arst_cnt", o_byte_cnt, 0);
        chk("arst_drop", o_drop, 0);
        chk("arst_valid", o_line_valid, 0);
        #1 rst = 1'b0;
        send_byte(8'h0A);
        chk("arst_nl_valid", o_line_valid, 1);
        chk("arst_nl_len", o_line_len, 0);
        chk("arst_nl_cnt", o_byte_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
